// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair.
// Radix-2 shift-add multiply, restoring divide, sign fix-up at the end.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 div_q, div_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 bz_q, bz_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic                 sa, sb;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       msum;
  logic [WIDTH:0]       rtr;
  logic [WIDTH:0]       dsub;
  logic [2*WIDTH-1:0]   mul_nxt, div_nxt;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot, rem;

  always_comb begin
    sa    = ~is_unsigned & a[WIDTH-1];
    sb    = ~is_unsigned & b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;

    msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    mul_nxt = acc_q[0] ? {msum, acc_q[WIDTH-1:1]}
                       : {1'b0, acc_q[2*WIDTH-1:1]};

    // rtr holds the shifted remainder including the bit pushed out the top
    rtr     = acc_q[2*WIDTH-1:WIDTH-1];
    dsub    = rtr - {1'b0, opb_q};
    div_nxt = dsub[WIDTH] ? {rtr[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                          : {dsub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod = neg_q ? -acc_q : acc_q;
    quot = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          if (!op[1]) begin
            state_d = RUN;
            cnt_d   = '0;
            div_d   = op[0];
            opb_d   = op[0] ? mag_b : mag_a;
            acc_d   = op[0] ? {{WIDTH{1'b0}}, mag_a}
                            : {{WIDTH{1'b0}}, mag_b};
            neg_d   = sa ^ sb;
            rneg_d  = sa;
            a_d     = a;
            bz_d    = (b == '0);
          end else if (op[0]) begin
            lo_d = a;
          end else begin
            hi_d = a;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = div_q ? div_nxt : mul_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!div_q) begin
            {hi_d, lo_d} = prod;
          end else if (bz_q) begin
            lo_d  = '1;
            hi_d  = a_q;
            dbz_d = 1'b1;
          end else begin
            lo_d = quot;
            hi_d = rem;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
